// File: rtl/instruction_fetch_unit.sv
// Fetch stage: pulses the counter, reads instruction memory, holds the returned
// word for the decoder over valid/ready, with branch flush and a sticky timeout error.
module instruction_fetch_unit #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        FU_clk,
  input  logic        FU_rst,
  input  logic        FU_run,
  input  logic        FU_flush,
  input  logic [7:0]  FU_pc_in,
  output logic        FU_pc_rd_en,
  output logic [7:0]  FU_mem_addr,
  output logic        FU_mem_rd_en,
  input  logic [15:0] FU_mem_data,
  input  logic        FU_mem_ack,
  output logic [15:0] FU_ir_out,
  output logic [3:0]  FU_opcode,
  output logic [3:0]  FU_reg_sel,
  output logic [7:0]  FU_imm,
  output logic        FU_valid,
  input  logic        FU_ready,
  output logic        FU_busy,
  output logic        FU_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PC_RD = 3'd1,
    ADDR  = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_mem_addr;
  logic [15:0] r_ir;
  logic [7:0]  r_tmo;
  logic        r_err;

  always_ff @(posedge FU_clk) begin
    if (FU_rst) begin
      r_state    <= IDLE;
      r_mem_addr <= 8'h00;
      r_ir       <= 16'h0000;
      r_tmo      <= 8'h00;
      r_err      <= 1'b0;
    end else if (FU_flush && r_state != IDLE) begin
      // Taken branch: drop whatever is in flight; the held word stays but loses valid.
      r_state <= FU_run ? PC_RD : IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (FU_run && !r_err) r_state <= PC_RD;
        end
        PC_RD: r_state <= ADDR;
        ADDR: begin
          r_mem_addr <= FU_pc_in;
          r_tmo      <= 8'h00;
          r_state    <= WAIT;
        end
        WAIT: begin
          if (FU_mem_ack) begin
            r_ir    <= FU_mem_data;
            r_state <= HOLD;
          end else if (r_tmo == TMO_LAST) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        HOLD: begin
          if (FU_ready) r_state <= FU_run ? PC_RD : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign FU_pc_rd_en  = (r_state == PC_RD);
  assign FU_mem_rd_en = (r_state == WAIT);
  assign FU_valid     = (r_state == HOLD);
  assign FU_busy      = (r_state != IDLE);
  assign FU_err       = r_err;
  assign FU_mem_addr  = r_mem_addr;
  assign FU_ir_out    = r_ir;
  assign FU_opcode    = r_ir[15:12];
  assign FU_reg_sel   = r_ir[11:8];
  assign FU_imm       = r_ir[7:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: latency, decoder stall, timeout,
// flush, run deassertion and reset-in-HOLD scenarios with hand-computed values.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, run, flush, ack, ready;
  logic [7:0]  pc_in;
  logic [15:0] mem_data;
  logic        pc_rd_en, mem_rd_en, valid, busy, err;
  logic [7:0]  mem_addr, imm;
  logic [15:0] ir_out;
  logic [3:0]  opcode, reg_sel;

  int n_checks = 0;
  int n_errors = 0;

  instruction_fetch_unit #(.TIMEOUT_CYCLES(15)) dut (
    .FU_clk(clk), .FU_rst(rst), .FU_run(run), .FU_flush(flush),
    .FU_pc_in(pc_in), .FU_pc_rd_en(pc_rd_en), .FU_mem_addr(mem_addr),
    .FU_mem_rd_en(mem_rd_en), .FU_mem_data(mem_data), .FU_mem_ack(ack),
    .FU_ir_out(ir_out), .FU_opcode(opcode), .FU_reg_sel(reg_sel), .FU_imm(imm),
    .FU_valid(valid), .FU_ready(ready), .FU_busy(busy), .FU_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; flush = 1'b0; ack = 1'b0; ready = 1'b0;
    pc_in = 8'h00; mem_data = 16'h0000;
    #2;
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_pcrd", pc_rd_en, 0);
    chk("rst_memrd", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 8'h00);
    chk("rst_ir", ir_out, 16'h0000);
    chk("rst_err", err, 0);

    // Basic fetch and back-to-back restart
    run = 1'b1; ready = 1'b1;
    tick();                                   // cycle 1: PC_RD
    chk("c1_pcrd", pc_rd_en, 1);
    chk("c1_busy", busy, 1);
    pc_in = 8'h01;
    tick();                                   // cycle 2: ADDR
    chk("c2_pcrd", pc_rd_en, 0);
    chk("c2_memrd", mem_rd_en, 0);
    tick();                                   // cycle 3: WAIT
    chk("c3_addr", mem_addr, 8'h01);
    chk("c3_memrd", mem_rd_en, 1);
    chk("c3_valid", valid, 0);
    ack = 1'b1; mem_data = 16'hA3F0;
    tick();                                   // cycle 4: HOLD
    ack = 1'b0;
    chk("c4_valid", valid, 1);
    chk("c4_opcode", opcode, 4'hA);
    chk("c4_regsel", reg_sel, 4'h3);
    chk("c4_imm", imm, 8'hF0);
    chk("c4_memrd", mem_rd_en, 0);
    tick();                                   // cycle 5: PC_RD again
    chk("c5_pcrd", pc_rd_en, 1);
    chk("c5_valid", valid, 0);

    // Decoder stall in HOLD
    ready = 1'b0; pc_in = 8'h02;
    tick(); tick();                           // ADDR, WAIT
    chk("st_addr", mem_addr, 8'h02);
    ack = 1'b1; mem_data = 16'h1234;
    tick();
    ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("st_valid", valid, 1);
      chk("st_ir", ir_out, 16'h1234);
      chk("st_pcrd", pc_rd_en, 0);
      tick();
    end
    ready = 1'b1; run = 1'b0;
    tick();
    chk("st_done_busy", busy, 0);
    chk("st_done_valid", valid, 0);
    chk("st_done_pcrd", pc_rd_en, 0);

    // Memory timeout
    run = 1'b1; ready = 1'b0;
    tick(); tick(); tick();                   // first WAIT cycle
    for (int i = 0; i < 15; i++) begin
      chk("to_memrd", mem_rd_en, 1);
      chk("to_err_lo", err, 0);
      tick();
    end
    chk("to_err", err, 1);
    chk("to_memrd_off", mem_rd_en, 0);
    chk("to_busy", busy, 0);
    tick(); tick();
    chk("to_stuck_busy", busy, 0);
    chk("to_stuck_pcrd", pc_rd_en, 0);
    chk("to_stuck_err", err, 1);
    run = 1'b0;
    do_reset();
    chk("to_rst_err", err, 0);

    // Flush during WAIT, late ack ignored
    run = 1'b1; pc_in = 8'h20;
    tick(); tick(); tick();                   // WAIT
    chk("fl_memrd", mem_rd_en, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_memrd_off", mem_rd_en, 0);
    chk("fl_pcrd", pc_rd_en, 1);
    ack = 1'b1; mem_data = 16'hDEAD;
    tick();                                   // ADDR, late ack seen here
    ack = 1'b0;
    chk("fl_valid", valid, 0);
    chk("fl_ir", ir_out, 16'h0000);
    tick();                                   // WAIT
    ack = 1'b1; mem_data = 16'h5A5A; ready = 1'b0;
    tick();                                   // HOLD
    ack = 1'b0;
    chk("fl_hold_ir", ir_out, 16'h5A5A);
    chk("fl_hold_valid", valid, 1);

    // Flush coinciding with a HOLD handshake cancels it
    run = 1'b0; flush = 1'b1; ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("flh_valid", valid, 0);
    chk("flh_busy", busy, 0);
    chk("flh_ir_kept", ir_out, 16'h5A5A);
    flush = 1'b1;                             // no effect in IDLE
    tick();
    flush = 1'b0;
    chk("fli_busy", busy, 0);

    // Run dropped during ADDR
    run = 1'b1; pc_in = 8'h10;
    tick(); tick();                           // ADDR
    run = 1'b0;
    tick();                                   // WAIT
    chk("rd_addr", mem_addr, 8'h10);
    chk("rd_memrd", mem_rd_en, 1);
    ack = 1'b1; mem_data = 16'hC0DE; ready = 1'b1;
    tick();
    ack = 1'b0;
    chk("rd_valid", valid, 1);
    chk("rd_ir", ir_out, 16'hC0DE);
    tick();
    chk("rd_idle_busy", busy, 0);
    chk("rd_idle_valid", valid, 0);
    tick();
    chk("rd_idle_pcrd", pc_rd_en, 0);

    // Reset while holding a valid instruction
    run = 1'b1; ready = 1'b0; pc_in = 8'h33;
    tick(); tick(); tick();
    ack = 1'b1; mem_data = 16'hBEEF;
    tick();
    ack = 1'b0;
    chk("rh_valid", valid, 1);
    run = 1'b0;
    do_reset();
    chk("rh_valid0", valid, 0);
    chk("rh_busy", busy, 0);
    chk("rh_ir", ir_out, 16'h0000);
    chk("rh_opcode", opcode, 4'h0);
    chk("rh_addr", mem_addr, 8'h00);
    chk("rh_memrd", mem_rd_en, 0);
    chk("rh_pcrd", pc_rd_en, 0);
    chk("rh_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage directly downstream of the instruction counter. Reads the counter's 8-bit output, issues a read to instruction memory, latches the returned 16-bit word into an instruction register, and presents it with its fields split out to the decoder over a valid/ready handshake. It also supports flush on a taken branch and raises a sticky error when memory does not acknowledge in time.

Parameters:
TIMEOUT_CYCLES, 15, max WAIT cycles without FU_mem_ack before error; legal range 1..255.

Ports:
FU_clk  input  1  clock, all state updates on rising edge
FU_rst  input  1  synchronous active-high reset
FU_run  input  1  level; 1 = keep fetching, 0 = stop at next instruction boundary
FU_flush  input  1  discard in-flight/held instruction (taken branch)
FU_pc_in  input  8  counter output value
FU_pc_rd_en  output  1  read-enable pulse to counter
FU_mem_addr  output  8  registered instruction memory address
FU_mem_rd_en  output  1  memory read request, held until ack
FU_mem_data  input  16  memory read data, valid when FU_mem_ack=1
FU_mem_ack  input  1  memory data valid strobe
FU_ir_out  output  16  latched instruction word
FU_opcode  output  4  FU_ir_out[15:12]
FU_reg_sel  output  4  FU_ir_out[11:8]
FU_imm  output  8  FU_ir_out[7:0]
FU_valid  output  1  instruction on FU_ir_out is valid
FU_ready  input  1  decoder accepts instruction when FU_valid=1
FU_busy  output  1  1 in any state other than IDLE
FU_err  output  1  sticky memory-timeout flag

Behaviour:
- Reset (FU_rst=1 at an edge, any state, overrides everything): state IDLE; FU_pc_rd_en=0, FU_mem_rd_en=0, FU_mem_addr=8'h00, FU_ir_out=16'h0000 (so opcode/reg_sel/imm=0), FU_valid=0, FU_busy=0, FU_err=0, timeout counter=0.
- States: IDLE, PC_RD, ADDR, WAIT, HOLD. All outputs are decoded from state/registers; no combinational path from inputs to outputs.
- IDLE: FU_run=1 and FU_err=0 -> PC_RD; otherwise stay.
- PC_RD: FU_pc_rd_en=1 for exactly this cycle; the counter updates its output on this edge. -> ADDR.
- ADDR: on the exit edge, FU_mem_addr <= FU_pc_in, timeout counter <= 0. -> WAIT.
- WAIT: FU_mem_rd_en=1. If FU_mem_ack=1: FU_ir_out <= FU_mem_data, -> HOLD. Else increment timeout counter; when it equals TIMEOUT_CYCLES-1 with no ack: FU_err <= 1, -> IDLE.
- HOLD: FU_valid=1; FU_ir_out stays stable. If FU_ready=1: transfer completes on this edge; -> PC_RD if FU_run=1, else IDLE. If FU_ready=0, stay.
- Latency: FU_run is sampled high in IDLE at edge 1; PC_RD is cycle 1, ADDR cycle 2, FU_mem_rd_en high from cycle 3. With ack in cycle 3, FU_valid=1 from cycle 4. Back-to-back throughput with zero-wait memory and ready held high is 1 instruction per 4 cycles.
- FU_run deasserted mid-fetch: the current fetch completes through HOLD, then -> IDLE.
- FU_flush=1 (lower priority than reset, higher than all else): from any non-IDLE state, FU_valid and FU_mem_rd_en drop on the next cycle; FU_ir_out is retained but invalid; -> PC_RD if FU_run=1, else IDLE. A flush while in IDLE has no effect. A flush coinciding with a HOLD handshake cancels the transfer, which counts as not accepted.
- FU_mem_ack outside WAIT is ignored. FU_ready outside HOLD is ignored.
- FU_err is cleared only by reset. While FU_err=1, the block stays in IDLE regardless of FU_run.
- FU_busy = (state != IDLE).

Test Plan:
- Reset then FU_run=1, FU_pc_in=8'h00 then 8'h01 after the pulse, memory acks in the first WAIT cycle with 16'hA3F0, FU_ready=1 -> FU_pc_rd_en high in cycle 1, FU_mem_addr=8'h01 in cycle 3, FU_valid cycle 4, opcode=4'hA, reg_sel=4'h3, imm=8'hF0.
- Decoder stalls: FU_ready=0 for 5 cycles in HOLD -> FU_valid stays 1 and FU_ir_out stays stable for all 5 cycles; no FU_pc_rd_en pulse until FU_ready=1.
- Memory never acks, TIMEOUT_CYCLES=15 -> FU_err=1 after 15 WAIT cycles, FU_mem_rd_en=0, FU_busy=0; FU_run=1 stays ignored until reset.
- FU_flush in WAIT with FU_run=1 -> FU_mem_rd_en=0 next cycle, state PC_RD; a late ack is ignored and FU_valid stays 0.
- FU_run dropped in ADDR -> fetch completes, FU_valid pulses after handshake, then IDLE with FU_busy=0.
- FU_rst asserted in HOLD with FU_valid=1 -> all outputs at reset values on the next cycle.
